// File: rtl/avalon_st_if.sv
// Avalon-ST streaming bundle: one data beat per valid&&ready, with packet
// delimiters (sop/eop) and an empty count of unused bytes on the eop beat.
interface avalon_st_if #(
   parameter int DATA_WIDTH_IN_BYTES = 16
);
   localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES > 2) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

   logic [DATA_WIDTH_IN_BYTES*8-1:0] data;
   logic                             valid;
   logic                             ready;
   logic                             sop;
   logic                             eop;
   logic [EMPTY_W-1:0]               empty;

   modport master (output data, valid, sop, eop, empty, input ready);
   modport slave  (input data, valid, sop, eop, empty, output ready);
endinterface

// File: rtl/avalon_st_pkt_gen.sv
// Avalon-ST packet source: on start, emits one packet of pkt_len bytes whose
// byte i is (seed + i) mod 256, honouring ready backpressure.
module avalon_st_pkt_gen #(
   parameter  int DATA_WIDTH_IN_BYTES = 16,
   parameter  int MAX_PKT_LEN_BYTES   = 4096,
   localparam int LEN_W = (MAX_PKT_LEN_BYTES + 1 > 2) ? $clog2(MAX_PKT_LEN_BYTES + 1) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] pkt_len,
   input  logic [7:0]       seed,
   output logic             busy,
   output logic             done,
   output logic             err,
   avalon_st_if.master      msg_out
);

   function automatic int log2up_func(input int v);
      return (v > 2) ? $clog2(v) : 1;
   endfunction

   localparam int DW      = DATA_WIDTH_IN_BYTES;
   localparam int DATA_W  = DW * 8;
   localparam int EMPTY_W = log2up_func(DW);
   localparam int OFF_W   = LEN_W + 1;

   typedef enum logic {IDLE, SEND} state_t;

   // Beat contents are derived from the byte offset of the beat's lane 0.
   function automatic logic [DATA_W-1:0] beat_data_f(input logic [7:0]       s,
                                                     input logic [OFF_W-1:0] off,
                                                     input logic [OFF_W-1:0] len);
      logic [DATA_W-1:0] d;
      logic [OFF_W-1:0]  idx;
      d = '0;
      for (int k = 0; k < DW; k++) begin
         idx = off + OFF_W'(k);
         if (idx < len) d[8*k +: 8] = s + 8'(idx);
      end
      return d;
   endfunction

   function automatic logic beat_eop_f(input logic [OFF_W-1:0] off,
                                       input logic [OFF_W-1:0] len);
      return (off + OFF_W'(DW)) >= len;
   endfunction

   function automatic logic [EMPTY_W-1:0] beat_empty_f(input logic [OFF_W-1:0] off,
                                                       input logic [OFF_W-1:0] len);
      logic [OFF_W-1:0] e;
      e = off + OFF_W'(DW) - len;
      return beat_eop_f(off, len) ? EMPTY_W'(e) : '0;
   endfunction

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [7:0]         seed_q, seed_d;
   logic [OFF_W-1:0]   off_q, off_d;
   logic [DATA_W-1:0]  data_q, data_d;
   logic               valid_q, valid_d;
   logic               sop_q, sop_d;
   logic               eop_q, eop_d;
   logic [EMPTY_W-1:0] empty_q, empty_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic [OFF_W-1:0]   off_nxt;
   logic [OFF_W-1:0]   len_ext;
   logic [OFF_W-1:0]   start_len;
   logic               len_ok;

   assign off_nxt   = off_q + OFF_W'(DW);
   assign len_ext   = {1'b0, len_q};
   assign start_len = {1'b0, pkt_len};
   assign len_ok    = (pkt_len != '0) && (pkt_len <= LEN_W'(MAX_PKT_LEN_BYTES));

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      seed_d  = seed_q;
      off_d   = off_q;
      data_d  = data_q;
      valid_d = valid_q;
      sop_d   = sop_q;
      eop_d   = eop_q;
      empty_d = empty_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (len_ok) begin
                  state_d = SEND;
                  len_d   = pkt_len;
                  seed_d  = seed;
                  off_d   = '0;
                  valid_d = 1'b1;
                  busy_d  = 1'b1;
                  sop_d   = 1'b1;
                  eop_d   = beat_eop_f('0, start_len);
                  empty_d = beat_empty_f('0, start_len);
                  data_d  = beat_data_f(seed, '0, start_len);
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         SEND: begin
            if (msg_out.ready) begin
               if (eop_q) begin
                  state_d = IDLE;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  sop_d   = 1'b0;
                  eop_d   = 1'b0;
                  empty_d = '0;
                  data_d  = '0;
               end else begin
                  off_d   = off_nxt;
                  sop_d   = 1'b0;
                  eop_d   = beat_eop_f(off_nxt, len_ext);
                  empty_d = beat_empty_f(off_nxt, len_ext);
                  data_d  = beat_data_f(seed_q, off_nxt, len_ext);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         len_q   <= '0;
         seed_q  <= '0;
         off_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         empty_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         seed_q  <= seed_d;
         off_q   <= off_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         sop_q   <= sop_d;
         eop_q   <= eop_d;
         empty_q <= empty_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign msg_out.data  = data_q;
   assign msg_out.valid = valid_q;
   assign msg_out.sop   = sop_q;
   assign msg_out.eop   = eop_q;
   assign msg_out.empty = empty_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;

endmodule

// File: tb/tb_avalon_st_pkt_gen.sv
// Bench for avalon_st_pkt_gen: table of packet requests plus directed
// backpressure, ignored-start, back-to-back and mid-packet reset sequences.
module tb_avalon_st_pkt_gen;

   localparam int DW = 16;

   logic        clk;
   logic        rst;
   logic        start;
   logic [12:0] pkt_len;
   logic [7:0]  seed;
   logic        busy;
   logic        done;
   logic        err;

   avalon_st_if #(.DATA_WIDTH_IN_BYTES(DW)) bus ();

   avalon_st_pkt_gen #(
      .DATA_WIDTH_IN_BYTES(DW),
      .MAX_PKT_LEN_BYTES  (4096)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .pkt_len(pkt_len),
      .seed   (seed),
      .busy   (busy),
      .done   (done),
      .err    (err),
      .msg_out(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [127:0] data;
      logic         sop;
      logic         eop;
      logic [3:0]   empty;
   } beat_t;

   typedef struct {
      int           len;
      logic [7:0]   seed;
      logic [7:0]   pat;
      logic         err;
      int           beats;
      int           empty;
      logic [127:0] d0;
   } vec_t;

   beat_t        exp_q[$];
   beat_t        mon_e;
   beat_t        held;
   logic         hold_vld;
   int           beat_cnt;
   int           last_empty;
   logic [127:0] first_data;
   int           n_vec;
   int           n_bad;
   vec_t         tbl[9];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: byte i of the packet is seed+i, beats of DW bytes.
   function automatic void push_exp(input int len, input logic [7:0] sd);
      int    beats;
      int    i;
      beat_t e;
      beats = (len + DW - 1) / DW;
      for (int b = 0; b < beats; b++) begin
         e.data = '0;
         for (int k = 0; k < DW; k++) begin
            i = b * DW + k;
            if (i < len) e.data[8*k +: 8] = sd + 8'(i);
         end
         e.sop   = (b == 0);
         e.eop   = (b == beats - 1);
         e.empty = e.eop ? 4'(beats * DW - len) : 4'd0;
         exp_q.push_back(e);
      end
   endfunction

   always @(negedge clk) begin
      if (bus.valid) begin
         if (hold_vld) begin
            check("hold_data", bus.data, held.data);
            check("hold_ctl", 128'({bus.sop, bus.eop, bus.empty}), 128'({held.sop, held.eop, held.empty}));
         end
         if (bus.ready) begin
            check("beat_expected", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check("beat_data", bus.data, mon_e.data);
               check("beat_sop", 128'(bus.sop), 128'(mon_e.sop));
               check("beat_eop", 128'(bus.eop), 128'(mon_e.eop));
               check("beat_empty", 128'(bus.empty), 128'(mon_e.empty));
            end
            beat_cnt++;
            if (bus.sop) first_data = bus.data;
            if (bus.eop) last_empty = int'(bus.empty);
            hold_vld = 1'b0;
         end else begin
            held.data  = bus.data;
            held.sop   = bus.sop;
            held.eop   = bus.eop;
            held.empty = bus.empty;
            hold_vld   = 1'b1;
         end
      end else begin
         hold_vld = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_pkt(input int len, input logic [7:0] sd);
      push_exp(len, sd);
      beat_cnt   = 0;
      last_empty = -1;
      first_data = '0;
      start      = 1'b1;
      pkt_len    = 13'(len);
      seed       = sd;
      tick();
      start = 1'b0;
      check("lat_valid", 128'(bus.valid), 128'(1));
      check("lat_busy", 128'(busy), 128'(1));
   endtask

   // Returns in the done cycle so a caller may issue the next start there.
   task automatic wait_done(input logic [7:0] pat, input int exp_beats, input int exp_empty);
      logic got;
      got = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         bus.ready = pat[c % 8];
         tick();
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      check("done_seen", 128'(got), 128'(1));
      check("beat_count", 128'(beat_cnt), 128'(exp_beats));
      check("last_empty", 128'(last_empty), 128'(exp_empty));
      check("queue_drained", 128'(exp_q.size()), 128'(0));
      check("valid_after_eop", 128'(bus.valid), 128'(0));
      check("busy_after_eop", 128'(busy), 128'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec     = 0;
      n_bad     = 0;
      hold_vld  = 1'b0;
      beat_cnt  = 0;
      rst       = 1'b1;
      start     = 1'b0;
      pkt_len   = '0;
      seed      = '0;
      bus.ready = 1'b0;

      tbl[0] = '{16,   8'h00, 8'hFF,        1'b0, 1,   0,  128'h0f0e0d0c0b0a09080706050403020100};
      tbl[1] = '{20,   8'hFE, 8'hFF,        1'b0, 2,   12, 128'h0d0c0b0a09080706050403020100fffe};
      tbl[2] = '{40,   8'h10, 8'b11101001,  1'b0, 3,   8,  128'h1f1e1d1c1b1a19181716151413121110};
      tbl[3] = '{1,    8'h55, 8'b01010101,  1'b0, 1,   15, 128'h55};
      tbl[4] = '{17,   8'h80, 8'b00110011,  1'b0, 2,   15, 128'h8f8e8d8c8b8a89888786858483828180};
      tbl[5] = '{4096, 8'h33, 8'b10110111,  1'b0, 256, 0,  128'h4241403f3e3d3c3b3a39383736353433};
      tbl[6] = '{0,    8'h00, 8'hFF,        1'b1, 0,   0,  128'h0};
      tbl[7] = '{4097, 8'h00, 8'hFF,        1'b1, 0,   0,  128'h0};
      tbl[8] = '{8191, 8'h00, 8'hFF,        1'b1, 0,   0,  128'h0};

      repeat (3) tick();
      check("rst_valid", 128'(bus.valid), 128'(0));
      check("rst_ctl", 128'({bus.sop, bus.eop, bus.empty}), 128'(0));
      check("rst_data", bus.data, 128'(0));
      check("rst_status", 128'({busy, done, err}), 128'(0));
      rst = 1'b0;
      tick();

      foreach (tbl[i]) begin
         if (tbl[i].err) begin
            start   = 1'b1;
            pkt_len = 13'(tbl[i].len);
            seed    = tbl[i].seed;
            tick();
            start = 1'b0;
            check("err_pulse", 128'(err), 128'(1));
            check("err_no_valid", 128'({bus.valid, busy}), 128'(0));
            tick();
            check("err_one_cycle", 128'(err), 128'(0));
            check("err_still_idle", 128'({bus.valid, busy}), 128'(0));
         end else begin
            start_pkt(tbl[i].len, tbl[i].seed);
            wait_done(tbl[i].pat, tbl[i].beats, tbl[i].empty);
            check("first_beat_data", first_data, tbl[i].d0);
            tick();
            check("done_one_cycle", 128'(done), 128'(0));
         end
      end

      // start during SEND is ignored while the sink stalls
      bus.ready = 1'b0;
      start_pkt(64, 8'h20);
      tick();
      tick();
      start   = 1'b1;
      pkt_len = 13'd5;
      seed    = 8'h00;
      tick();
      start = 1'b0;
      check("ign_no_err", 128'(err), 128'(0));
      check("ign_busy", 128'(busy), 128'(1));
      check("ign_stall_sop", 128'({bus.valid, bus.sop}), 128'(2'b11));
      wait_done(8'hFF, 4, 0);
      repeat (3) tick();
      check("ign_no_second_pkt", 128'({bus.valid, busy}), 128'(0));

      // start issued in the done cycle is accepted
      start_pkt(20, 8'h01);
      wait_done(8'hFF, 2, 12);
      start_pkt(2, 8'h07);
      check("b2b_sop_eop", 128'({bus.sop, bus.eop}), 128'(2'b11));
      wait_done(8'hFF, 1, 14);
      tick();

      // reset in the middle of a packet truncates it without done
      start_pkt(64, 8'h40);
      bus.ready = 1'b1;
      tick();
      bus.ready = 1'b0;
      tick();
      check("pre_rst_valid", 128'(bus.valid), 128'(1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_valid", 128'(bus.valid), 128'(0));
      check("rst_mid_busy", 128'(busy), 128'(0));
      check("rst_mid_no_done", 128'(done), 128'(0));
      tick();
      check("rst_mid_no_done2", 128'({done, bus.valid}), 128'(0));
      exp_q.delete();
      start_pkt(3, 8'hAA);
      wait_done(8'hFF, 1, 13);
      check("post_rst_data", first_data, 128'hacabaa);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
